id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 16-bit, 8-register pipeline; sits directly downstream of the instruction decoder / control unit.
- Captures decoded control, operands, immediate and register fields each cycle and presents them to the EX stage.
- Resolves the write-register index (Rt / Rd / $r7).
- Detects load-use hazards and inserts bubbles; supports a global freeze and branch/jump flush.

Parameters:
- DATA_W, 16, datapath / PC / immediate width
- REG_AW, 3, register index width (8 registers; $r0 hardwired zero)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  global hold (memory wait); ID/EX keeps contents
- flush  in  1  branch/jump/JR taken in EX; squash incoming ID instruction
- id_valid  in  1  ID stage holds a real instruction
- id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_branch, id_jump, id_bne, id_jr  in  1 each  decoded control
- id_alu_control  in  3  ALU op
- id_reg_dst  in  2  00=Rd (R-type), 01=Rt (I-type), 10=$r7 (JAL), 11 reserved→Rd
- id_mem_to_reg  in  2  00=ALU, 01=memory, 10=PC+1
- id_pc_plus1, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+1, register operands, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW each  instruction register fields
- hazard_stall  out  1  combinational; upstream holds PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_* (every id_* control/data/field above, same widths)  out  registered copies
- ex_wreg  out  REG_AW  resolved destination register

Behaviour:
- Reset: all ex_* outputs, ex_valid and ex_wreg = 0, giving a NOP bubble (reg_write, mem_read, mem_write, branch, jump, bne, jr all 0).
- Per-edge priority, highest first: rst > freeze (hold all) > flush (bubble) > hazard_stall (bubble) > load.
- Bubble: ex_valid and every control output = 0. Data and field outputs also = 0, so the bubble is deterministic.
- Load: all ex_* <= id_*, with ex_valid <= id_valid. Control outputs load as id_* & id_valid, so an invalid slot is always a NOP.
- ex_wreg on load: reg_dst 10→7, 01→id_rt, else id_rd. Forced to 0 when id_reg_write = 0.
- hazard_stall = ex_valid & ex_mem_read & (ex_wreg != 0) & id_valid & ~flush & ~freeze & (ex_wreg==id_rs | (uses_rt & ex_wreg==id_rt)).
  - uses_rt = ~id_alu_src | id_mem_write | id_branch | id_bne.
- Latency: 1 cycle ID→EX. A load-use pair costs exactly one bubble: after the bubble, ex_mem_read = 0, so hazard_stall deasserts.
- freeze & flush together: hold. Flush is re-presented by EX after the freeze releases.
- rst mid-freeze: reset wins.
- JR (R-type, funct 101) passes through as ex_jr. Its register read uses rs, so it is covered by the hazard rule.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: adds outputs perf_bubbles and perf_hazards, 16 bits each, saturating at 16'hFFFF, cleared by rst.
  - perf_bubbles: +1 per edge on which a bubble is loaded (flush or hazard, not freeze).
  - perf_hazards: +1 per cycle hazard_stall = 1 and freeze = 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package aura16_pkg:
  - DATA_W and REG_AW defaults
  - REG_LINK = 3'd7
  - RegDst codes, MemToReg codes, ALU control encodings
  - a packed control-bundle typedef (reg_write … jr, 13 bits)
- Sub-module load_use_detect: combinational hazard_stall and uses_rt decode.
- id_ex_stage_reg holds the registers, priority mux and optional counters.

Test Plan:
- rst=1 for 2 cycles with id_* all 1s → all ex_* = 0, ex_valid = 0, hazard_stall = 0.
- ADD r3,r1,r2 (reg_dst=00, id_rd=3), id_valid=1 → next cycle ex_wreg = 3, ex_reg_write = 1, ex_rd1/ex_rd2 = id values.
- LW r2,0(r1) (reg_dst=01, rt=2), then ADD r4,r2,r5 → hazard_stall = 1 for one cycle, one bubble (ex_valid = 0), then ADD loads; perf_hazards = 1, perf_bubbles = 1.
- LW to r0 followed by a consumer of r0 → hazard_stall = 0. ADDI r6,r2,#1 after LW r2 → stall (uses rs). SW with rt=2 after LW r2 → stall.
- JAL (reg_dst=10, mem_to_reg=10, pc_plus1=16'h0041) → ex_wreg = 7, ex_jump = 1, ex_pc_plus1 = 16'h0041. flush=1 same cycle → bubble instead.
- freeze=1 for 3 cycles with changing id_* and flush=1 → ex_* unchanged. After release, the next edge loads the current id_*.

Source files
------------

// File: rtl/aura16_pkg.sv
// Shared constants and types for the aura16 16-bit, 8-register pipeline.
package aura16_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 3;
   localparam logic [2:0] REG_LINK = 3'd7;

   typedef enum logic [1:0] {
      REG_DST_RD   = 2'b00,
      REG_DST_RT   = 2'b01,
      REG_DST_LINK = 2'b10,
      REG_DST_RSVD = 2'b11
   } reg_dst_e;

   typedef enum logic [1:0] {
      MEM_TO_REG_ALU  = 2'b00,
      MEM_TO_REG_MEM  = 2'b01,
      MEM_TO_REG_PC1  = 2'b10,
      MEM_TO_REG_RSVD = 2'b11
   } mem_to_reg_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_ctrl_e;

   // Everything that must read as zero for a slot to be a NOP.
   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       mem_read;
      logic       branch;
      logic       jump;
      logic       bne;
      logic       jr;
      logic [2:0] alu_control;
      logic [1:0] mem_to_reg;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module load_use_detect
   import aura16_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_wreg,
   input  logic              id_valid,
   input  logic              flush,
   input  logic              freeze,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_bne,
   output logic              hazard_stall
);

   logic uses_rt_s;
   logic rs_match_s;
   logic rt_match_s;

   // rt is a source for R-type, stores and both branch flavours; $r0 never stalls.
   always_comb begin
      uses_rt_s    = ~id_alu_src | id_mem_write | id_branch | id_bne;
      rs_match_s   = (ex_wreg == id_rs);
      rt_match_s   = uses_rt_s & (ex_wreg == id_rt);
      hazard_stall = ex_valid & ex_mem_read & (ex_wreg != {REG_AW{1'b0}}) &
                     id_valid & ~flush & ~freeze & (rs_match_s | rt_match_s);
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with write-register resolve, bubble insertion and freeze.
// Optional ID_EX_PERF_EN adds saturating bubble / hazard event counters.
module id_ex_stage_reg
   import aura16_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic              id_reg_write,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic              id_branch,
   input  logic              id_jump,
   input  logic              id_bne,
   input  logic              id_jr,
   input  logic [2:0]        id_alu_control,
   input  logic [1:0]        id_reg_dst,
   input  logic [1:0]        id_mem_to_reg,
   input  logic [DATA_W-1:0] id_pc_plus1,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_alu_src,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_bne,
   output logic              ex_jr,
   output logic [2:0]        ex_alu_control,
   output logic [1:0]        ex_reg_dst,
   output logic [1:0]        ex_mem_to_reg,
   output logic [DATA_W-1:0] ex_pc_plus1,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] ex_wreg
`ifdef ID_EX_PERF_EN
   ,
   output logic [15:0]       perf_bubbles,
   output logic [15:0]       perf_hazards
`endif
);

   typedef struct packed {
      logic              valid;
      ctrl_t             ctrl;
      logic [1:0]        reg_dst;
      logic [DATA_W-1:0] pc_plus1;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] wreg;
   } stage_t;

   stage_t            stage_r;
   stage_t            load_s;
   ctrl_t             ctrl_in_s;
   logic [REG_AW-1:0] wreg_s;
   logic              bubble_s;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .ex_valid     (stage_r.valid),
      .ex_mem_read  (stage_r.ctrl.mem_read),
      .ex_wreg      (stage_r.wreg),
      .id_valid     (id_valid),
      .flush        (flush),
      .freeze       (freeze),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_alu_src   (id_alu_src),
      .id_mem_write (id_mem_write),
      .id_branch    (id_branch),
      .id_bne       (id_bne),
      .hazard_stall (hazard_stall)
   );

   // Build the load image; an invalid slot carries zeroed control so it is a NOP.
   always_comb begin
      ctrl_in_s = '{id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_branch,
                    id_jump, id_bne, id_jr, id_alu_control, id_mem_to_reg};
      case (reg_dst_e'(id_reg_dst))
         REG_DST_LINK: wreg_s = REG_AW'(REG_LINK);
         REG_DST_RT:   wreg_s = id_rt;
         default:      wreg_s = id_rd;
      endcase
      load_s          = '0;
      load_s.valid    = id_valid;
      load_s.ctrl     = ctrl_t'(ctrl_in_s & {CTRL_W{id_valid}});
      load_s.reg_dst  = id_reg_dst;
      load_s.pc_plus1 = id_pc_plus1;
      load_s.rd1      = id_rd1;
      load_s.rd2      = id_rd2;
      load_s.imm      = id_imm;
      load_s.rs       = id_rs;
      load_s.rt       = id_rt;
      load_s.rd       = id_rd;
      if (id_reg_write) begin
         load_s.wreg = wreg_s;
      end else begin
         load_s.wreg = {REG_AW{1'b0}};
      end
      bubble_s = flush | hazard_stall;
   end

   // Stage register: reset, then freeze hold, then bubble, then load.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r <= '0;
      end else if (freeze) begin
         stage_r <= stage_r;
      end else if (bubble_s) begin
         stage_r <= '0;
      end else begin
         stage_r <= load_s;
      end
   end

   assign ex_valid       = stage_r.valid;
   assign ex_reg_write   = stage_r.ctrl.reg_write;
   assign ex_alu_src     = stage_r.ctrl.alu_src;
   assign ex_mem_write   = stage_r.ctrl.mem_write;
   assign ex_mem_read    = stage_r.ctrl.mem_read;
   assign ex_branch      = stage_r.ctrl.branch;
   assign ex_jump        = stage_r.ctrl.jump;
   assign ex_bne         = stage_r.ctrl.bne;
   assign ex_jr          = stage_r.ctrl.jr;
   assign ex_alu_control = stage_r.ctrl.alu_control;
   assign ex_mem_to_reg  = stage_r.ctrl.mem_to_reg;
   assign ex_reg_dst     = stage_r.reg_dst;
   assign ex_pc_plus1    = stage_r.pc_plus1;
   assign ex_rd1         = stage_r.rd1;
   assign ex_rd2         = stage_r.rd2;
   assign ex_imm         = stage_r.imm;
   assign ex_rs          = stage_r.rs;
   assign ex_rt          = stage_r.rt;
   assign ex_rd          = stage_r.rd;
   assign ex_wreg        = stage_r.wreg;

`ifdef ID_EX_PERF_EN
   logic [15:0] perf_bubbles_r;
   logic [15:0] perf_hazards_r;

   // Saturating event counters; a frozen edge loads nothing so counts nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles_r <= 16'h0000;
         perf_hazards_r <= 16'h0000;
      end else begin
         if (!freeze && bubble_s && (perf_bubbles_r != 16'hFFFF)) begin
            perf_bubbles_r <= perf_bubbles_r + 16'h0001;
         end
         if (!freeze && hazard_stall && (perf_hazards_r != 16'hFFFF)) begin
            perf_hazards_r <= perf_hazards_r + 16'h0001;
         end
      end
   end

   assign perf_bubbles = perf_bubbles_r;
   assign perf_hazards = perf_hazards_r;
`endif

endmodule
